// File: rtl/audio_pkg.sv
// audio_pkg: shared sample types, widths and WM8731 defaults for the audio path
// Contents: SAMPLE_BITS, sample_t, sample_pair_t, default BCLK_DIV/SLOT_BITS,
//           condition_pair() which applies channel swap then mute to a pair.
package audio_pkg;
    localparam int SAMPLE_BITS = 16;
    localparam int WM8731_BCLK_DIV = 8;
    localparam int WM8731_SLOT_BITS = 32;
    typedef logic [SAMPLE_BITS-1:0] sample_t;
    typedef struct packed {
        sample_t left;
        sample_t right;
    } sample_pair_t;
    // Swap happens before mute, so a muted swapped pair is still all zeros.
    function automatic sample_pair_t condition_pair(input sample_pair_t p, input logic exchan, input logic mute);
        sample_pair_t q;
        q = exchan ? {p.right, p.left} : p;
        return mute ? '0 : q;
    endfunction
endpackage

// File: rtl/i2s_dac_shifter_if.sv
// i2s_dac_shifter_if: sample-side bundle between the system core and the I2S shifter
// Signals: audio_l/audio_r (two's complement samples), mute, exchan driven by the core;
//          sample_strobe returned by the shifter when a pair is latched.
// Modports: master = core side, slave = shifter side.
interface i2s_dac_shifter_if;
    import audio_pkg::*;
    sample_t audio_l;
    sample_t audio_r;
    logic mute;
    logic exchan;
    logic sample_strobe;
    modport master (output audio_l, audio_r, mute, exchan, input sample_strobe);
    modport slave (input audio_l, audio_r, mute, exchan, output sample_strobe);
endinterface

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: codec master clock and bit clock generator
// Ports: clk, reset (sync, active-high) in; aud_xck = clk/2, aud_bclk with a
//        half-period of BCLK_DIV clk cycles, fall_evt = high in the cycle whose
//        edge drives aud_bclk from 1 to 0.
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    output logic aud_xck,
    output logic aud_bclk,
    output logic fall_evt
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    logic [DW-1:0] div_cnt;
    logic tick;
    assign tick = div_cnt == DIV_LAST;
    // Combinational so the parent updates its serial state on the same edge
    // that drops aud_bclk.
    assign fall_evt = tick && aud_bclk;
    always_ff @(posedge clk) begin
        if (reset) begin
            aud_xck <= 1'b0;
            aud_bclk <= 1'b0;
            div_cnt <= '0;
        end else begin
            aud_xck <= ~aud_xck;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) aud_bclk <= ~aud_bclk;
        end
    end
endmodule

// File: rtl/i2s_dac_shifter.sv
// i2s_dac_shifter: serialises 16-bit L/R samples into an I2S (Philips) stream for a WM8731 DAC
// Ports: clk, reset (sync, active-high); smp (slave side of i2s_dac_shifter_if:
//        audio_l, audio_r, mute, exchan in, sample_strobe out); aud_xck, aud_bclk,
//        aud_daclrck (0 = left slot), aud_dacdat to the codec pins. All outputs registered.
module i2s_dac_shifter
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = WM8731_BCLK_DIV,
    parameter int SLOT_BITS = WM8731_SLOT_BITS
) (
    input  logic clk,
    input  logic reset,
    i2s_dac_shifter_if.slave smp,
    output logic aud_xck,
    output logic aud_bclk,
    output logic aud_daclrck,
    output logic aud_dacdat
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] RIGHT_START = CW'(SLOT_BITS);
    logic fall_evt;
    logic wrap;
    logic strobe;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] next_cnt;
    logic [FRAME_BITS-1:0] frame;
    logic [FRAME_BITS-1:0] next_frame;
    sample_pair_t pair;
    i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
        .clk(clk),
        .reset(reset),
        .aud_xck(aud_xck),
        .aud_bclk(aud_bclk),
        .fall_evt(fall_evt)
    );
    assign wrap = bit_cnt == LAST;
    assign next_cnt = wrap ? '0 : bit_cnt + 1'b1;
    assign pair = condition_pair({smp.audio_l, smp.audio_r}, smp.exchan, smp.mute);
    assign smp.sample_strobe = strobe;
    // Frame bit i is index i: left MSB at 0, right MSB at SLOT_BITS, padding zeros after each.
    always_comb begin
        next_frame = '0;
        for (int i = 0; i < SAMPLE_BITS; i++) begin
            next_frame[i] = pair.left[SAMPLE_BITS-1-i];
            next_frame[SLOT_BITS+i] = pair.right[SAMPLE_BITS-1-i];
        end
    end
    // The one-bit I2S delay means the bit shown at new count k is frame bit k-1,
    // which is always the current count (including the wrap, where it is the
    // last bit of the outgoing frame, read before the reload below).
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            frame <= '0;
            aud_daclrck <= 1'b0;
            aud_dacdat <= 1'b0;
            strobe <= 1'b0;
        end else begin
            strobe <= fall_evt && wrap;
            if (fall_evt) begin
                bit_cnt <= next_cnt;
                aud_daclrck <= next_cnt >= RIGHT_START;
                aud_dacdat <= frame[bit_cnt];
                if (wrap) frame <= next_frame;
            end
        end
    end
endmodule

// File: tb/tb_i2s_dac_shifter.sv
// tb_i2s_dac_shifter: checks two shifters (16-bit and 32-bit slots) against a time-based model
module tb_i2s_dac_shifter;
    logic clk = 1'b0;
    logic reset;
    logic run = 1'b0;
    logic xa, ba, la, da, xb, bb, lb, db;
    int total = 0;
    int bad = 0;
    int ta = 0, tb2 = 0;
    logic [31:0] cur_a = '0, prev_a = '0, cur_b = '0, prev_b = '0;
    i2s_dac_shifter_if ia();
    i2s_dac_shifter_if ib();
    i2s_dac_shifter #(.BCLK_DIV(2), .SLOT_BITS(16)) dut_a (
        .clk(clk), .reset(reset), .smp(ia.slave),
        .aud_xck(xa), .aud_bclk(ba), .aud_daclrck(la), .aud_dacdat(da)
    );
    i2s_dac_shifter #(.BCLK_DIV(2), .SLOT_BITS(32)) dut_b (
        .clk(clk), .reset(reset), .smp(ib.slave),
        .aud_xck(xb), .aud_bclk(bb), .aud_daclrck(lb), .aud_dacdat(db)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
        end
    endtask
    // Pair {left,right} as the codec should receive it.
    function automatic logic [31:0] pick(input logic [15:0] l, r, input logic ex, mu);
        if (mu) return 32'h0;
        return ex ? {r, l} : {l, r};
    endfunction
    // Frame bit i of a pair laid out in slots of s bits.
    function automatic logic fbit(input logic [31:0] p, input int i, s);
        if (i < 16) return p[31-i];
        if (i >= s && i < s + 16) return p[15-(i-s)];
        return 1'b0;
    endfunction
    // Expected {xck, bclk, lrck, dat, strobe} after t clock edges since reset.
    function automatic logic [4:0] expv(input int t, d, s, input logic [31:0] cur, prev);
        int k;
        logic x, b, l, dt, st;
        k = (t / (2 * d)) % (2 * s);
        x = (t % 2) == 1;
        b = ((t / d) % 2) == 1;
        l = k >= s;
        dt = (k == 0) ? fbit(prev, 2 * s - 1, s) : fbit(cur, k - 1, s);
        st = t > 0 && (t % (4 * d * s)) == 0;
        return {x, b, l, dt, st};
    endfunction
    always @(posedge clk) begin
        if (reset) begin
            ta <= 0; tb2 <= 0;
            cur_a <= '0; prev_a <= '0; cur_b <= '0; prev_b <= '0;
        end else begin
            ta <= ta + 1;
            tb2 <= tb2 + 1;
            if ((ta + 1) % 128 == 0) begin
                prev_a <= cur_a;
                cur_a <= pick(ia.audio_l, ia.audio_r, ia.exchan, ia.mute);
            end
            if ((tb2 + 1) % 256 == 0) begin
                prev_b <= cur_b;
                cur_b <= pick(ib.audio_l, ib.audio_r, ib.exchan, ib.mute);
            end
        end
    end
    always @(negedge clk) begin
        if (run) begin
            chk("model_a", {59'd0, xa, ba, la, da, ia.sample_strobe}, {59'd0, expv(ta, 2, 16, cur_a, prev_a)});
            chk("model_b", {59'd0, xb, bb, lb, db, ib.sample_strobe}, {59'd0, expv(tb2, 2, 32, cur_b, prev_b)});
        end
    end
    // Edges after release until the first bclk fall and first strobe of dut_a.
    task automatic measure(output int fall_at, output int strobe_at);
        logic pb;
        pb = 1'b0;
        fall_at = 0;
        strobe_at = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (fall_at == 0 && pb && !ba) fall_at = i;
            pb = ba;
            if (ia.sample_strobe) begin
                strobe_at = i;
                break;
            end
        end
    endtask
    // Collect n data bits, one per bit clock (4 clk), MSB first.
    task automatic decode(input bit use_b, input int n, output logic [63:0] w, output int hi);
        w = '0;
        hi = 0;
        for (int i = 0; i < n; i++) begin
            repeat (4) @(negedge clk);
            w = {w[62:0], use_b ? db : da};
            hi += use_b ? int'(lb) : int'(la);
        end
    endtask
    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        int fa, sa_at, hi, n;
        logic [63:0] w;
        reset = 1'b1;
        ia.audio_l = 16'hA5C3; ia.audio_r = 16'h3C5A; ia.mute = 1'b0; ia.exchan = 1'b0;
        ib.audio_l = 16'h8001; ib.audio_r = 16'h1234; ib.mute = 1'b0; ib.exchan = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        run = 1'b1;
        chk("reset_a", {59'd0, xa, ba, la, da, ia.sample_strobe}, 64'd0);
        chk("reset_b", {59'd0, xb, bb, lb, db, ib.sample_strobe}, 64'd0);
        reset = 1'b0;
        measure(fa, sa_at);
        chk("first_fall", 64'(fa), 64'd4);
        chk("first_strobe", 64'(sa_at), 64'd128);
        decode(1'b0, 32, w, hi);
        chk("pattern", w, 64'h0000_0000_A5C3_3C5A);
        chk("lrck_high_a", 64'(hi), 64'd16);
        chk("strobe_a_256", 64'(ia.sample_strobe), 64'd1);
        chk("strobe_b_256", 64'(ib.sample_strobe), 64'd1);
        ia.exchan = 1'b1;
        repeat (128) @(negedge clk);
        chk("strobe_a_384", 64'(ia.sample_strobe), 64'd1);
        decode(1'b0, 32, w, hi);
        chk("exchan", w, 64'h0000_0000_3C5A_A5C3);
        chk("wide_period", 64'(ib.sample_strobe), 64'd1);
        decode(1'b1, 64, w, hi);
        chk("wide_slot", w, 64'h8001_0000_1234_0000);
        chk("lrck_high_b", 64'(hi), 64'd32);
        repeat (40) @(negedge clk);
        ia.mute = 1'b1;
        ia.audio_l = 16'($urandom);
        ia.audio_r = 16'($urandom);
        repeat (88) @(negedge clk);
        decode(1'b0, 32, w, hi);
        chk("mute", w, 64'd0);
        ia.mute = 1'b0;
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) begin
                ia.audio_l = 16'($urandom); ia.audio_r = 16'($urandom);
                ia.exchan = 1'($urandom); ia.mute = $urandom_range(3) == 0;
                ib.audio_l = 16'($urandom); ib.audio_r = 16'($urandom);
                ib.exchan = 1'($urandom); ib.mute = $urandom_range(3) == 0;
            end
        end
        n = 0;
        while (n < 200 && !(ta % 4 == 0 && (ta / 4) % 32 == 20)) begin
            @(negedge clk);
            n++;
        end
        chk("find_bit20", 64'(n < 200), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_a", {59'd0, xa, ba, la, da, ia.sample_strobe}, 64'd0);
        chk("midreset_b", {59'd0, xb, bb, lb, db, ib.sample_strobe}, 64'd0);
        reset = 1'b0;
        measure(fa, sa_at);
        chk("refall", 64'(fa), 64'd4);
        chk("restrobe", 64'(sa_at), 64'd128);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
